logic_sweep_checker: RTL and testbench

//  Multi-lane, registered successor of the 4-input checker f = ((x&y)|(z&w)) & (y&w).

---
 rtl/logic_sweep_checker.sv | 109 ++++++++++
 tb/tb_logic_sweep_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker: multi-lane registered f=y&w&(x|z) in three styles with a 16-vector self-test sweep.
// Optional lane-0 gate-level fault injection port inj when FAULT_INJ_EN is defined.
module logic_sweep_checker #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] w,
  input  logic [LANES-1:0] x,
  input  logic [LANES-1:0] y,
  input  logic [LANES-1:0] z,
`ifdef FAULT_INJ_EN
  input  logic             inj,
`endif
  output logic [LANES-1:0] outB,
  output logic [LANES-1:0] outD,
  output logic [LANES-1:0] outG,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             mismatch
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d;
  logic [LANES-1:0] outb_q, outb_d, outd_q, outd_d, outg_q, outg_d;
  logic [LANES-1:0] fb_all, fd_all, fg_all;
  logic [CNT_W:0] pc, sum;
  logic sweep;
  assign sweep = (state_q == SWEEP);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [3:0] v;
    logic lw, lx, ly, lz, fb, o1, fg_raw;
    assign v  = k_q + 4'(i);
    assign lw = sweep ? v[3] : w[i];
    assign lx = sweep ? v[2] : x[i];
    assign ly = sweep ? v[1] : y[i];
    assign lz = sweep ? v[0] : z[i];
    always_comb fb = (ly && lw) ? (lx || lz) : 1'b0;
    assign fd_all[i] = ly & lw & (lx | lz);
    or  u_or  (o1, lx, lz);
    and u_and (fg_raw, ly, lw, o1);
    assign fb_all[i] = fb;
`ifdef FAULT_INJ_EN
    assign fg_all[i] = fg_raw ^ (inj && (i == 0));
`else
    assign fg_all[i] = fg_raw;
`endif
  end
  always_comb begin
    pc = '0;
    for (int j = 0; j < LANES; j++) pc = pc + (CNT_W+1)'(outb_q[j]);
  end
  assign sum = {1'b0, cnt_q} + pc;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q | (outb_q != outd_q) | (outb_q != outg_q);
    outb_d  = fb_all;
    outd_d  = fd_all;
    outg_d  = fg_all;
    // results are counted one cycle behind the vector that produced them
    if ((sweep && k_q != 4'd0) || state_q == DRAIN)
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    if (state_q == IDLE && start) begin
      state_d = SWEEP;
      k_d     = '0;
      cnt_d   = '0;
      mis_d   = 1'b0;
    end else if (sweep) begin
      k_d     = k_q + 4'd1;
      state_d = (k_q == 4'd15) ? DRAIN : SWEEP;
    end else if (state_q == DRAIN) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      outb_q  <= '0;
      outd_q  <= '0;
      outg_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      outb_q  <= outb_d;
      outd_q  <= outd_d;
      outg_q  <= outg_d;
    end
  end
  always_comb begin
    busy = (state_q == SWEEP) || (state_q == DRAIN);
    done = (state_q == DONE);
  end
  assign outB     = outb_q;
  assign outD     = outd_q;
  assign outG     = outg_q;
  assign ones_cnt = cnt_q;
  assign mismatch = mis_q;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// tb_logic_sweep_checker: directed scoreboard bench for logic_sweep_checker (LANES=4, CNT_W=8).
module tb_logic_sweep_checker;
  localparam int L = 4;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [L-1:0] w = '0, x = '0, y = '0, z = '0;
  logic [L-1:0] outB, outD, outG;
  logic busy, done, mismatch;
  logic [CW-1:0] ones_cnt;
`ifdef FAULT_INJ_EN
  logic inj = 1'b0;
`endif
  int checks = 0, failures = 0;
  logic [31:0] sb[$];

  logic_sweep_checker #(.LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .w(w), .x(x), .y(y), .z(z),
`ifdef FAULT_INJ_EN
    .inj(inj),
`endif
    .outB(outB), .outD(outD), .outG(outG), .busy(busy), .done(done),
    .ones_cnt(ones_cnt), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // f is true only for {w,x,y,z} = 1011, 1110, 1111
  function automatic logic fn(input logic [3:0] n);
    return (n == 4'd11) || (n == 4'd14) || (n == 4'd15);
  endfunction

  function automatic logic [31:0] trio(input logic [L-1:0] e);
    return 32'({e, e, e});
  endfunction

  function automatic logic [L-1:0] sweep_exp(input int k);
    logic [L-1:0] e;
    logic [3:0] n;
    for (int i = 0; i < L; i++) begin
      n = 4'((k + i) % 16);
      e[i] = fn(n);
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] status;
    return 32'({busy, done, ones_cnt, mismatch});
  endfunction

  // entered right after the start edge; optional second start at busy cycle restart_at
  task automatic sweep_checked(input int restart_at);
    int n;
    n = 0;
    while (busy && n < 40) begin
      if (n >= 1) check("sweep_out", 32'({outB, outD, outG}));
      if (n < 16) push(trio(sweep_exp(n)));
      start = (n == restart_at);
      tick;
      n++;
    end
    start = 1'b0;
    sb.delete();
    push(17);
    check("busy_cycles", n);
  endtask

  initial begin
    logic [L-1:0] e;
    int saw;
    tick;
    tick;
    push(0); check("rst_trio", 32'({outB, outD, outG}));
    push(0); check("rst_status", status());
    rst = 1'b0;
    w = 4'b0001; x = 4'b0001; y = 4'b0001; z = 4'b0000;
    push(trio(4'b0001));
    tick;
    check("idle_wxy", 32'({outB, outD, outG}));
    x = 4'b0000;
    push(trio(4'b0000));
    tick;
    check("idle_wy", 32'({outB, outD, outG}));
    for (int r = 0; r < 4; r++) begin
      w = 4'($urandom); x = 4'($urandom); y = 4'($urandom); z = 4'($urandom);
      for (int i = 0; i < L; i++) e[i] = fn({w[i], x[i], y[i], z[i]});
      push(trio(e));
      tick;
      check("idle_rand", 32'({outB, outD, outG}));
    end
    push(0); check("idle_mismatch", 32'(mismatch));
    start = 1'b1;
    tick;
    start = 1'b0;
    sweep_checked(-1);
    push(32'({1'b0, 1'b1, 8'd12, 1'b0})); check("done_status", status());
    start = 1'b1;
    tick;
    start = 1'b0;
    push(32'({1'b0, 1'b0, 8'd12, 1'b0})); check("done_one_cycle", status());
    tick;
    push(32'({1'b0, 1'b0, 8'd12, 1'b0})); check("start_in_done_ignored", status());
    start = 1'b1;
    tick;
    start = 1'b0;
    sweep_checked(5);
    push(32'({1'b0, 1'b1, 8'd12, 1'b0})); check("restart_ignored", status());
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    push(1); check("busy_at_k7", 32'(busy));
    rst = 1'b1;
    #1;
    push(0); check("midsweep_rst_status", status());
    push(0); check("midsweep_rst_trio", 32'({outB, outD, outG}));
    tick;
    rst = 1'b0;
    saw = 0;
    repeat (20) begin
      tick;
      saw = saw | 32'(done);
    end
    push(0); check("no_done_after_rst", saw);
    start = 1'b1;
    tick;
    start = 1'b0;
    sweep_checked(-1);
    push(32'({1'b0, 1'b1, 8'd12, 1'b0})); check("fresh_sweep", status());
`ifdef FAULT_INJ_EN
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    inj = 1'b1;
    tick;
    inj = 1'b0;
    saw = 0;
    while (busy && saw < 40) begin
      tick;
      saw++;
    end
    push(32'({1'b0, 1'b1, 8'd12, 1'b1})); check("inj_mismatch", status());
    tick;
    push(1); check("inj_sticky", 32'(mismatch));
    start = 1'b1;
    tick;
    start = 1'b0;
    push(0); check("inj_cleared", 32'(mismatch));
    sweep_checked(-1);
    push(32'({1'b0, 1'b1, 8'd12, 1'b0})); check("inj_clean_sweep", status());
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
